// File: rtl/fifo_level_control_if.sv
// Request/status bundle between a FIFO user and fifo_level_control.
// master: issues write/read requests; slave: the level controller.
interface fifo_level_control_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  write;
  logic                  read;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, read,
    input  wr_en, rd_en, write_address, read_address, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write, read,
    output wr_en, rd_en, write_address, read_address, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_control.sv
// Pointer/occupancy/flag controller for a single-clock FIFO with external storage.
// Define FIFO_LEVEL_CONTROL_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_level_control #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                clk,
  input  logic                areset,
  fifo_level_control_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wptr_r;
  logic [ADDR_WIDTH:0] rptr_r;
  logic [ADDR_WIDTH:0] count_r;
  logic [ADDR_WIDTH:0] count_nxt_s;
  logic                full_r;
  logic                empty_r;
  logic                almost_full_r;
  logic                almost_empty_r;
  logic                wr_en_s;
  logic                rd_en_s;

  // A read while full frees the slot the simultaneous write needs.
  assign wr_en_s = bus.write & (~full_r | bus.read);
  assign rd_en_s = bus.read & ~empty_r;

  // Occupancy after this edge; flags are derived from it so they move with count.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and level flags.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wptr_r         <= {(ADDR_WIDTH+1){1'b0}};
      rptr_r         <= {(ADDR_WIDTH+1){1'b0}};
      count_r        <= {(ADDR_WIDTH+1){1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + ONE_C;
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + ONE_C;
      end
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == DEPTH_C);
      empty_r        <= (count_nxt_s == {(ADDR_WIDTH+1){1'b0}});
      almost_full_r  <= (count_nxt_s >= AF_C);
      almost_empty_r <= (count_nxt_s <= AE_C);
    end
  end

`ifdef FIFO_LEVEL_CONTROL_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags, cleared only by areset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.write & full_r & ~bus.read) begin
        overflow_r <= 1'b1;
      end
      if (bus.read & empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.wr_en         = wr_en_s;
  assign bus.rd_en         = rd_en_s;
  assign bus.write_address = wptr_r[ADDR_WIDTH-1:0];
  assign bus.read_address  = rptr_r[ADDR_WIDTH-1:0];
  assign bus.count         = count_r;
  assign bus.full          = full_r;
  assign bus.empty         = empty_r;
  assign bus.almost_full   = almost_full_r;
  assign bus.almost_empty  = almost_empty_r;
endmodule
